fila_reader: RTL and testbench
==============================

Name: fila_reader

Overview:
Consumer/drain side of the team's 8-entry byte queue interface (enqueue/dequeue/len protocol).
- Watches the queue's occupancy and issues single-cycle dequeue pulses.
- Captures the registered queue output byte and presents it downstream on a valid/ready handshake.
- Keeps a delivered-byte counter.
- Sits between the queue instance and any byte-stream consumer.

Parameters:
DATA_W, 8, width of queue data and downstream data
LEN_W, 8, width of the queue occupancy input
CNT_W, 16, width of the delivered-byte counter

Ports:
clock  input  1  clock, rising edge
reset  input  1  asynchronous, active-high reset
enable  input  1  1 = allowed to start new dequeues
q_len  input  LEN_W  queue occupancy, registered in queue, updated at the dequeue edge
q_data  input  DATA_W  queue registered output; valid from the cycle after the dequeue edge, held until the next dequeue
q_deq  output  1  dequeue request to queue, registered, one-cycle pulse
m_data  output  DATA_W  downstream byte
m_valid  output  1  downstream byte valid
m_ready  input  1  downstream accepts byte
busy  output  1  1 whenever state != IDLE
count_out  output  CNT_W  bytes accepted downstream since reset

Behaviour:
- Reset: reset is asynchronous, active-high; clock is clock.
  - On reset: q_deq=0, m_data=0, m_valid=0, busy=0, count_out=0, state=IDLE.
  - Reset mid-operation abandons the in-flight byte. A byte already dequeued but not yet accepted downstream is lost; this is intended.
- FSM states: IDLE, POP, CAPT, HOLD. All outputs are registered.
- IDLE: if enable && q_len != 0, set q_deq<=1 and go to POP. Otherwise stay, with q_deq=0.
- POP: q_deq is high during this cycle; the queue dequeues at the ending edge. Set q_deq<=0 and go to CAPT. q_len is not sampled in POP, because it is stale.
- CAPT: set m_data<=q_data, m_valid<=1, go to HOLD.
- HOLD: m_valid=1. m_data must remain stable while m_ready=0.
  - On an edge with m_ready=1: m_valid<=0, count_out<=count_out+1, go to IDLE.
- Latency: the first q_deq edge occurs 1 cycle after IDLE sees q_len != 0. m_valid rises 2 cycles after the q_deq edge.
- Throughput: at most one byte per 4 cycles with m_ready tied high.
- q_deq is never high for two consecutive cycles.
- q_deq is never asserted while a byte is pending in CAPT or HOLD.
- enable: only gates the IDLE->POP transition. Deasserting enable mid-transfer lets the current byte complete to IDLE, and nothing new starts.
- Empty queue (q_len=0) in IDLE: no request; busy=0.
- count_out wraps modulo 2^CNT_W, with no saturation.
- m_ready while m_valid=0 is ignored.

Optional Feature:
FILA_READER_SUM_EN
- Defined:
  - Adds output port sum_out [DATA_W-1:0], registered and reset to 0.
  - On each HOLD edge with m_ready=1, sum_out <= sum_out XOR m_data.
  - sum_out is a running checksum of delivered bytes and does not change on reset-free idle cycles.
- Undefined: sum_out port and logic absent; all other behaviour identical.

Test Plan:
1. Assert reset for 3 cycles mid-HOLD with m_valid=1 -> same cycle q_deq=0, m_valid=0, m_data=0, count_out=0, busy=0. After release, the block stays in IDLE while q_len=0.
2. Behavioural queue preloaded with 0x11,0x22,0x33, enable=1, m_ready=1 ->
   - exactly 3 single-cycle q_deq pulses, each 4 cycles apart;
   - m_data sequence 0x11,0x22,0x33;
   - count_out=3, then busy=0 and q_len=0.
3. Queue holds 0xA5, m_ready=0 for 10 cycles after m_valid rises -> m_valid stays 1, m_data stays 0xA5, no further q_deq. Then m_ready=1 for one cycle -> m_valid=0 next cycle, count_out=1.
4. q_len=5, enable=0 for 20 cycles -> q_deq never asserted. Then enable=1 and drop enable during the first HOLD -> exactly one byte delivered, count_out=1, q_len=4.
5. m_ready held high continuously with q_len=8 -> q_deq never high on consecutive cycles, 8 bytes delivered in 32 cycles, count_out=8.
6. With FILA_READER_SUM_EN, deliver 0x0F,0xF0,0x55 -> sum_out=0xAA. Without the macro, the same stimulus compiles and passes tests 1-5.

Source files
------------

// File: rtl/fila_reader.sv
// Drain side of the 8-entry byte queue: pops one byte at a time and offers it downstream on valid/ready.
// Optional build macro FILA_READER_SUM_EN adds sum_out, an XOR checksum of every byte accepted downstream.
module fila_reader #(
  parameter int DATA_W = 8,
  parameter int LEN_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic [LEN_W-1:0]  q_len,
  input  logic [DATA_W-1:0] q_data,
  output logic              q_deq,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
`ifdef FILA_READER_SUM_EN
  output logic [DATA_W-1:0] sum_out,
`endif
  output logic [CNT_W-1:0]  count_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    CAPT = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic              q_deq_q, q_deq_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic              m_valid_q, m_valid_d;
  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              accept;

  assign accept = (state_q == HOLD) && m_ready;

  always_comb begin
    state_d   = state_q;
    q_deq_d   = 1'b0;
    m_data_d  = m_data_q;
    m_valid_d = m_valid_q;
    count_d   = count_q;
    case (state_q)
      IDLE: begin
        if (enable && (q_len != '0)) begin
          q_deq_d = 1'b1;
          state_d = POP;
        end
      end
      // q_len is stale here: the queue only updates it at the edge ending this cycle.
      POP: state_d = CAPT;
      CAPT: begin
        m_data_d  = q_data;
        m_valid_d = 1'b1;
        state_d   = HOLD;
      end
      HOLD: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          count_d   = count_q + CNT_ONE;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      q_deq_q   <= 1'b0;
      m_data_q  <= '0;
      m_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      q_deq_q   <= q_deq_d;
      m_data_q  <= m_data_d;
      m_valid_q <= m_valid_d;
      busy_q    <= busy_d;
      count_q   <= count_d;
    end
  end

`ifdef FILA_READER_SUM_EN
  logic [DATA_W-1:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (accept) begin
      sum_d = sum_q ^ m_data_q;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign sum_out = sum_q;
`else
  logic unused_accept;
  assign unused_accept = accept;
`endif

  assign q_deq     = q_deq_q;
  assign m_data    = m_data_q;
  assign m_valid   = m_valid_q;
  assign busy      = busy_q;
  assign count_out = count_q;

endmodule

// File: tb/tb_fila_reader.sv
// Bench for fila_reader: behavioural byte queue, scoreboard of expected bytes, directed and random phases.
// Build with FILA_READER_SUM_EN defined to also check sum_out.
module tb_fila_reader;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        m_ready = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  q_len;
  logic [7:0]  q_data = 8'h00;
  logic        q_deq;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        busy;
  logic [15:0] count_out;
`ifdef FILA_READER_SUM_EN
  logic [7:0]  sum_out;
`endif

  fila_reader #(.DATA_W(8), .LEN_W(8), .CNT_W(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .enable    (enable),
    .q_len     (q_len),
    .q_data    (q_data),
    .q_deq     (q_deq),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .busy      (busy),
`ifdef FILA_READER_SUM_EN
    .sum_out   (sum_out),
`endif
    .count_out (count_out)
  );

  always #5 clock = ~clock;

  // Behavioural queue: storage written by stimulus, read pointer advanced on dequeue edges.
  logic [7:0] mem [0:255];
  int push_cnt = 0;
  int pop_cnt  = 0;
  assign q_len = 8'(push_cnt - pop_cnt);

  always @(posedge clock) begin
    if (flush) begin
      pop_cnt <= push_cnt;
    end else if (q_deq) begin
      q_data  <= mem[pop_cnt[7:0]];
      pop_cnt <= pop_cnt + 1;
    end
  end

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q [$];
  int   model_count = 0;
  logic [7:0] model_sum = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[push_cnt[7:0]] = b;
    push_cnt++;
    exp_q.push_back(b);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    flush = 1'b1;
    repeat (3) @(negedge clock);
    flush = 1'b0;
    reset = 1'b0;
  endtask

  // Runs until the queue is empty and the reader is idle; reports dequeue timing.
  task automatic drain(input string name, input int maxc, output int deqs, output int first,
                       output int last, output int done_cyc);
    bit done = 1'b0;
    deqs = 0; first = -1; last = -1; done_cyc = -1;
    for (int c = 0; c < maxc && !done; c++) begin
      @(negedge clock);
      if (q_deq) begin
        if (first < 0) first = c;
        last = c;
        deqs++;
      end
      if (q_len == 8'd0 && !busy && !q_deq && !m_valid) begin
        done = 1'b1;
        done_cyc = c;
      end
    end
    chk({name, "_drained"}, 32'(done), 32'd1);
  endtask

  task automatic wait_valid(input string name, input int maxc);
    bit seen = 1'b0;
    for (int c = 0; c < maxc && !seen; c++) begin
      @(negedge clock);
      if (m_valid) seen = 1'b1;
    end
    chk({name, "_valid_seen"}, 32'(seen), 32'd1);
  endtask

  // Monitor: pops the scoreboard on every downstream handshake and checks protocol rules.
  logic       mon_pv = 1'b0;
  logic       mon_pr = 1'b0;
  logic       mon_pd = 1'b0;
  logic [7:0] mon_pdata = 8'h00;
  logic [7:0] mon_exp;

  initial begin
    forever begin
      @(negedge clock);
      #1;
      if (reset) begin
        while (exp_q.size() > int'(q_len)) void'(exp_q.pop_front());
        model_count = 0;
        model_sum   = 8'h00;
        mon_pv = 1'b0; mon_pr = 1'b0; mon_pd = 1'b0;
      end else begin
        if (q_deq) begin
          chk("deq_not_consecutive", 32'(mon_pd), 32'd0);
          chk("deq_while_pending", 32'(m_valid), 32'd0);
          chk("deq_nonempty", 32'(q_len != 8'd0), 32'd1);
        end
        if (mon_pv && !mon_pr) begin
          chk("valid_held", 32'(m_valid), 32'd1);
          chk("data_stable", 32'(m_data), 32'(mon_pdata));
        end
        if (m_valid && m_ready) begin
          chk("count_before_accept", 32'(count_out), 32'(model_count));
`ifdef FILA_READER_SUM_EN
          chk("sum_before_accept", 32'(sum_out), 32'(model_sum));
`endif
          chk("scoreboard_nonempty", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) begin
            mon_exp = exp_q.pop_front();
            chk("m_data", 32'(m_data), 32'(mon_exp));
            model_sum = model_sum ^ mon_exp;
          end
          model_count = (model_count + 1) % 65536;
        end
        mon_pv = m_valid; mon_pr = m_ready; mon_pd = q_deq; mon_pdata = m_data;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int deqs, first, last, done_cyc, n, cnt;
    logic [7:0] rx, b;

    // Test 1: reset asserted while a byte sits in HOLD.
    repeat (3) @(negedge clock);
    reset = 1'b0;
    chk("rst_count", 32'(count_out), 32'd0);
    enable = 1'b1; m_ready = 1'b0;
    push(8'h77);
    wait_valid("t1", 10);
    repeat (2) @(negedge clock);
    reset = 1'b1; flush = 1'b1;
    #1;
    chk("rst_q_deq", 32'(q_deq), 32'd0);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data", 32'(m_data), 32'd0);
    chk("rst_count_mid", 32'(count_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    repeat (3) @(negedge clock);
    flush = 1'b0; reset = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(negedge clock);
      if (busy || q_deq) cnt++;
    end
    chk("idle_empty_activity", 32'(cnt), 32'd0);

    // Test 2: three bytes at full rate.
    do_reset();
    enable = 1'b1; m_ready = 1'b1;
    push(8'h11); push(8'h22); push(8'h33);
    drain("t2", 40, deqs, first, last, done_cyc);
    chk("t2_deqs", 32'(deqs), 32'd3);
    chk("t2_deq_spacing", 32'(last - first), 32'd8);
    chk("t2_count", 32'(count_out), 32'd3);
    chk("t2_scoreboard_empty", 32'(exp_q.size()), 32'd0);

    // Test 3: downstream stalls for 10 cycles.
    do_reset();
    enable = 1'b1; m_ready = 1'b0;
    push(8'hA5);
    wait_valid("t3", 10);
    push(8'hB6);
    cnt = 0;
    repeat (10) begin
      @(negedge clock);
      if (!m_valid || m_data != 8'hA5 || q_deq) cnt++;
    end
    chk("t3_stall_violations", 32'(cnt), 32'd0);
    m_ready = 1'b1;
    @(negedge clock);
    m_ready = 1'b0;
    chk("t3_valid_drop", 32'(m_valid), 32'd0);
    chk("t3_count", 32'(count_out), 32'd1);
    m_ready = 1'b1;
    drain("t3", 40, deqs, first, last, done_cyc);
    chk("t3_count_final", 32'(count_out), 32'd2);

    // Test 4: enable gating, then enable dropped during the first HOLD.
    do_reset();
    enable = 1'b0; m_ready = 1'b1;
    for (int i = 0; i < 5; i++) push(8'(8'h40 + i));
    cnt = 0;
    repeat (20) begin
      @(negedge clock);
      if (q_deq) cnt++;
    end
    chk("t4_no_deq_disabled", 32'(cnt), 32'd0);
    enable = 1'b1;
    wait_valid("t4", 10);
    enable = 1'b0;
    repeat (10) @(negedge clock);
    chk("t4_count", 32'(count_out), 32'd1);
    chk("t4_q_len", 32'(q_len), 32'd4);
    chk("t4_busy", 32'(busy), 32'd0);

    // Test 5: eight bytes back to back.
    do_reset();
    enable = 1'b1; m_ready = 1'b1;
    for (int i = 0; i < 8; i++) push(8'($urandom));
    drain("t5", 60, deqs, first, last, done_cyc);
    chk("t5_deqs", 32'(deqs), 32'd8);
    chk("t5_deq_span", 32'(last - first), 32'd28);
    chk("t5_cycles", 32'(done_cyc + 1), 32'd32);
    chk("t5_count", 32'(count_out), 32'd8);

    // Test 6: checksum bytes.
    do_reset();
    enable = 1'b1; m_ready = 1'b1;
    push(8'h0F); push(8'hF0); push(8'h55);
    drain("t6", 40, deqs, first, last, done_cyc);
    chk("t6_count", 32'(count_out), 32'd3);
`ifdef FILA_READER_SUM_EN
    chk("t6_sum", 32'(sum_out), 32'hAA);
    repeat (5) @(negedge clock);
    chk("t6_sum_idle", 32'(sum_out), 32'hAA);
`endif

    // Random phase: random enable, ready and enqueue traffic.
    do_reset();
    n = 0; rx = 8'h00;
    for (int c = 0; c < 600; c++) begin
      @(negedge clock);
      enable  = ($urandom_range(0, 3) != 0);
      m_ready = ($urandom_range(0, 1) != 0);
      if ($urandom_range(0, 5) == 0 && q_len < 8'd20) begin
        b = 8'($urandom);
        push(b);
        rx = rx ^ b;
        n++;
      end
    end
    enable = 1'b1; m_ready = 1'b1;
    drain("rand", 200, deqs, first, last, done_cyc);
    chk("rand_count", 32'(count_out), 32'(n));
    chk("rand_scoreboard_empty", 32'(exp_q.size()), 32'd0);
`ifdef FILA_READER_SUM_EN
    chk("rand_sum", 32'(sum_out), 32'(rx));
`endif

    repeat (2) @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
